pc_predict_unit: RTL and testbench
==================================

Name: pc_predict_unit

Overview:
- Parametrised next-generation program-counter unit for the fetch stage.
- Holds the architectural fetch PC and selects the next PC from three sources: execute-stage redirect, branch-target-buffer (BTB) prediction, or sequential increment.
- Supports fetch stall and carries a direct-mapped BTB with 2-bit saturating counters.
- Exports the prediction made for the current PC so the execute stage can detect mispredicts and drive redirect/update.

Parameters:
- DATA_WIDTH, 32, width of PC and all address/target buses.
- RESET_PC, 32'h0000_0000, value loaded into PC on reset.
- BTB_ENTRIES, 8, number of BTB entries; power of two, >= 2.
- PC_INC, 4, sequential increment added to PC.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC; no sequential or predicted advance.
- redirect_valid  input  1  execute stage demands fetch from redirect_target.
- redirect_target  input  DATA_WIDTH  corrected next PC (branch/JAL/JALR target or fall-through).
- update_valid  input  1  resolved control-transfer information for BTB training.
- update_pc  input  DATA_WIDTH  PC of the resolved control-transfer instruction.
- update_target  input  DATA_WIDTH  resolved target of that instruction.
- update_taken  input  1  resolved direction of that instruction.
- PC  output  DATA_WIDTH  current fetch PC.
- pred_taken  output  1  BTB predicts taken for current PC.
- pred_target  output  DATA_WIDTH  predicted target for current PC; equals PC+PC_INC when pred_taken=0.

Behaviour:
- IDX = log2(BTB_ENTRIES).
- Index = PC[IDX+1:2].
- Tag = PC[DATA_WIDTH-1:IDX+2].
- Each entry holds: valid, tag, target (DATA_WIDTH), ctr (2 bits).
- Reset (async, any time incl. mid-stall or mid-redirect):
  - PC=RESET_PC; all valid bits cleared.
  - Tag/target/ctr contents need not be cleared.
  - pred_taken=0 and pred_target=RESET_PC+PC_INC while in reset.
- Lookup is combinational on current PC.
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? entry.target : PC+PC_INC.
- Next-PC priority, registered on the rising edge:
  - 1. redirect_valid: PC <= redirect_target. Overrides stall.
  - 2. stall: PC holds.
  - 3. otherwise: PC <= pred_target.
- Latency:
  - Redirect is visible on PC the cycle after redirect_valid is sampled.
  - No bubble is inserted by this block; squash of wrong-path fetches is the pipeline's job.
- Arithmetic: PC+PC_INC wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC + 4 = 0). Targets are taken unmodified; no alignment masking.
- BTB update on update_valid, written at the clock edge, independent of stall and redirect:
  - Tag hit at update_pc index: ctr saturating +1 if taken, -1 if not taken (bounds 0..3); target <= update_target only when taken.
  - Miss and taken: allocate/overwrite entry with valid=1, tag, target, ctr=2'b10 (weakly taken).
  - Miss and not taken: no change.
- Same-cycle update and lookup on the same index: lookup uses the pre-update contents; the new contents are visible from the next cycle.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Only ctr[1] drives prediction.
- No internal FSM beyond the PC register and BTB arrays; all outputs derive from registered state.

Test Plan:
- Reset then 3 free cycles, BTB empty -> PC sequence 0x0, 0x4, 0x8, 0xC; pred_taken=0 throughout.
- stall=1 for 2 cycles at PC=0x8 -> PC stays 0x8; releases to 0xC. redirect_valid=1 (target 0x100) while stall=1 -> PC=0x100 next cycle.
- update_valid, update_pc=0x10, update_target=0x40, taken=1; then run to PC=0x10 -> pred_taken=1, pred_target=0x40, next PC=0x40. Aliasing PC 0x30 (same index 4, different tag) -> pred_taken=0.
- Train 0x10 not-taken twice after allocation (ctr 2->1->0) -> pred_taken=0, PC 0x10 -> 0x14. Train taken twice (0->1->2) -> predicts taken again. Four taken updates from ctr=2 -> ctr stays 3.
- Same-cycle update of index 4 (0x10 -> 0x80) while PC=0x10 with old target 0x40 -> that cycle next PC=0x40; at next visit of 0x10 -> 0x80.
- PC=0xFFFF_FFFC, no hit -> PC wraps to 0x0. Assert rst mid-run with redirect_valid=1 -> PC=RESET_PC immediately; all BTB entries miss after release.

Source files
------------

// File: rtl/pc_predict_unit_if.sv
// Fetch-stage PC unit bundle: pipeline control/training inputs towards the
// PC unit, current PC and its prediction back out.
interface pc_predict_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  update_valid;
  logic [DATA_WIDTH-1:0] update_pc;
  logic [DATA_WIDTH-1:0] update_target;
  logic                  update_taken;
  logic [DATA_WIDTH-1:0] PC;
  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_target;

  modport master (
    output stall, redirect_valid, redirect_target,
    output update_valid, update_pc, update_target, update_taken,
    input  PC, pred_taken, pred_target
  );

  modport slave (
    input  stall, redirect_valid, redirect_target,
    input  update_valid, update_pc, update_target, update_taken,
    output PC, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC register with next-PC selection (redirect > stall > prediction)
// and a direct-mapped BTB of 2-bit saturating direction counters.
module pc_predict_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(32'h0000_0000),
  parameter int                    BTB_ENTRIES = 8,
  parameter int                    PC_INC      = 4
) (
  input logic                clk,
  input logic                rst,
  pc_predict_unit_if.slave   bus
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX - 2;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [DATA_WIDTH-1:0]  pc_r;
  logic [BTB_ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]       tag_r    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_r [BTB_ENTRIES];
  logic [1:0]             ctr_r    [BTB_ENTRIES];

  logic [IDX-1:0]        lk_idx_s;
  logic [TAG_W-1:0]      lk_tag_s;
  logic                  lk_hit_s;
  logic [DATA_WIDTH-1:0] seq_pc_s;
  logic                  pred_taken_s;
  logic [DATA_WIDTH-1:0] pred_target_s;
  logic [DATA_WIDTH-1:0] next_pc_s;

  logic [IDX-1:0]        upd_idx_s;
  logic [TAG_W-1:0]      upd_tag_s;
  logic                  upd_hit_s;
  logic                  upd_alloc_s;
  logic                  upd_train_s;
  logic [1:0]            upd_ctr_s;
  logic                  unused_pc_low_s;

  assign lk_idx_s  = pc_r[IDX+1:2];
  assign lk_tag_s  = pc_r[DATA_WIDTH-1:IDX+2];
  assign lk_hit_s  = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
  assign upd_idx_s = bus.update_pc[IDX+1:2];
  assign upd_tag_s = bus.update_pc[DATA_WIDTH-1:IDX+2];
  assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
  assign unused_pc_low_s = ^{pc_r[1:0], bus.update_pc[1:0]};

  // Lookup on the current PC and next-PC selection
  always_comb begin
    seq_pc_s      = pc_r + DATA_WIDTH'(PC_INC);
    pred_taken_s  = lk_hit_s & ctr_r[lk_idx_s][1];
    pred_target_s = seq_pc_s;
    next_pc_s     = pc_r;
    if (pred_taken_s) begin
      pred_target_s = target_r[lk_idx_s];
    end else begin
      pred_target_s = seq_pc_s;
    end
    if (bus.redirect_valid) begin
      next_pc_s = bus.redirect_target;
    end else if (bus.stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pred_target_s;
    end
  end

  // Training decode: train an existing entry on tag hit, allocate on taken miss
  always_comb begin
    upd_alloc_s = 1'b0;
    upd_train_s = 1'b0;
    upd_ctr_s   = ctr_r[upd_idx_s];
    if (bus.update_valid) begin
      if (upd_hit_s) begin
        upd_train_s = 1'b1;
      end else begin
        upd_alloc_s = bus.update_taken;
      end
    end else begin
      upd_train_s = 1'b0;
    end
    if (bus.update_taken) begin
      upd_ctr_s = ctr_inc(ctr_r[upd_idx_s]);
    end else begin
      upd_ctr_s = ctr_dec(ctr_r[upd_idx_s]);
    end
  end

  // PC register and BTB valid bits, the only reset state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= RESET_PC;
      valid_r <= '0;
    end else begin
      pc_r <= next_pc_s;
      if (upd_alloc_s) begin
        valid_r[upd_idx_s] <= 1'b1;
      end
    end
  end

  // BTB payload; contents are meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (upd_alloc_s) begin
      tag_r[upd_idx_s]    <= upd_tag_s;
      target_r[upd_idx_s] <= bus.update_target;
      ctr_r[upd_idx_s]    <= 2'b10;
    end else if (upd_train_s) begin
      ctr_r[upd_idx_s] <= upd_ctr_s;
      if (bus.update_taken) begin
        target_r[upd_idx_s] <= bus.update_target;
      end
    end
  end

  assign bus.PC          = pc_r;
  assign bus.pred_taken  = pred_taken_s;
  assign bus.pred_target = pred_target_s;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: sequential flow, stall/redirect,
// BTB allocation/training/saturation, same-cycle update, wrap and reset.
module tb_pc_predict_unit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  pc_predict_unit_if #(.DATA_WIDTH(32)) bus ();

  pc_predict_unit #(
    .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .BTB_ENTRIES(8), .PC_INC(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_update(input logic v, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic tk);
    bus.update_valid  = v;
    bus.update_pc     = pc;
    bus.update_target = tgt;
    bus.update_taken  = tk;
  endtask

  task automatic set_redirect(input logic v, input logic [31:0] tgt);
    bus.redirect_valid  = v;
    bus.redirect_target = tgt;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    set_redirect(1'b0, 32'h0);
    set_update(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("rst_pc", bus.PC, 32'h0);
    check("rst_ptaken", {31'd0, bus.pred_taken}, 32'h0);
    check("rst_ptarget", bus.pred_target, 32'h4);
    rst = 1'b0;

    // Free run from reset with an empty BTB
    check("seq0", bus.PC, 32'h0);
    tick(); check("seq1", bus.PC, 32'h4);
    tick(); check("seq2", bus.PC, 32'h8);
    check("seq2_ptaken", {31'd0, bus.pred_taken}, 32'h0);

    // Stall two cycles at 0x8, then release
    bus.stall = 1'b1;
    tick(); check("stall1", bus.PC, 32'h8);
    tick(); check("stall2", bus.PC, 32'h8);
    bus.stall = 1'b0;
    tick(); check("stall_rel", bus.PC, 32'hC);

    // Redirect overrides stall
    bus.stall = 1'b1;
    set_redirect(1'b1, 32'h100);
    tick(); check("redir_stall", bus.PC, 32'h100);
    bus.stall = 1'b0;
    set_redirect(1'b0, 32'h0);

    // Allocate 0x10 -> 0x40, then visit 0x10
    set_update(1'b1, 32'h10, 32'h40, 1'b1);
    tick(); check("alloc_seq", bus.PC, 32'h104);
    set_update(1'b0, 32'h0, 32'h0, 1'b0);
    set_redirect(1'b1, 32'h10);
    tick();
    set_redirect(1'b0, 32'h0);
    check("hit_ptaken", {31'd0, bus.pred_taken}, 32'h1);
    check("hit_ptarget", bus.pred_target, 32'h40);
    tick(); check("hit_next", bus.PC, 32'h40);

    // Aliasing PC 0x30: same index, different tag
    set_redirect(1'b1, 32'h30);
    tick();
    set_redirect(1'b0, 32'h0);
    check("alias_ptaken", {31'd0, bus.pred_taken}, 32'h0);
    check("alias_ptarget", bus.pred_target, 32'h34);

    // Two not-taken updates: ctr 2 -> 1 -> 0
    set_update(1'b1, 32'h10, 32'h40, 1'b0);
    tick(); tick();
    set_update(1'b0, 32'h0, 32'h0, 1'b0);
    set_redirect(1'b1, 32'h10);
    tick();
    set_redirect(1'b0, 32'h0);
    check("nt_ptaken", {31'd0, bus.pred_taken}, 32'h0);
    check("nt_ptarget", bus.pred_target, 32'h14);
    tick(); check("nt_next", bus.PC, 32'h14);

    // Taken updates while parked on 0x10: ctr 0 -> 1 (NT) -> 2 (T)
    set_redirect(1'b1, 32'h10);
    set_update(1'b1, 32'h10, 32'h40, 1'b1);
    tick(); check("tk1_ptaken", {31'd0, bus.pred_taken}, 32'h0);
    tick(); check("tk2_ptaken", {31'd0, bus.pred_taken}, 32'h1);
    check("tk2_ptarget", bus.pred_target, 32'h40);

    // Four more taken saturate at 3; one not-taken must still predict taken
    for (int i = 0; i < 4; i++) tick();
    check("sat_ptaken", {31'd0, bus.pred_taken}, 32'h1);
    set_update(1'b1, 32'h10, 32'h40, 1'b0);
    tick(); check("sat_dec1", {31'd0, bus.pred_taken}, 32'h1);
    tick(); check("sat_dec2", {31'd0, bus.pred_taken}, 32'h0);
    set_update(1'b1, 32'h10, 32'h40, 1'b1);
    tick(); check("retrain", {31'd0, bus.pred_taken}, 32'h1);

    // Same-cycle update of the looked-up entry uses the old target
    set_redirect(1'b0, 32'h0);
    set_update(1'b1, 32'h10, 32'h80, 1'b1);
    tick(); check("same_cyc_next", bus.PC, 32'h40);
    set_update(1'b0, 32'h0, 32'h0, 1'b0);
    set_redirect(1'b1, 32'h10);
    tick();
    set_redirect(1'b0, 32'h0);
    check("new_ptarget", bus.pred_target, 32'h80);
    tick(); check("new_next", bus.PC, 32'h80);

    // Wrap at the top of the address space
    set_redirect(1'b1, 32'hFFFF_FFFC);
    tick();
    set_redirect(1'b0, 32'h0);
    check("wrap_ptarget", bus.pred_target, 32'h0);
    tick(); check("wrap_pc", bus.PC, 32'h0);

    // Async reset in the middle of a redirect
    set_redirect(1'b1, 32'h200);
    tick(); check("pre_rst", bus.PC, 32'h200);
    rst = 1'b1;
    #1;
    check("async_rst_pc", bus.PC, 32'h0);
    check("async_rst_ptaken", {31'd0, bus.pred_taken}, 32'h0);
    check("async_rst_ptarget", bus.pred_target, 32'h4);
    tick(); check("rst_hold_pc", bus.PC, 32'h0);
    rst = 1'b0;
    set_redirect(1'b1, 32'h10);
    tick();
    set_redirect(1'b0, 32'h0);
    check("post_rst_miss", {31'd0, bus.pred_taken}, 32'h0);
    check("post_rst_ptarget", bus.pred_target, 32'h14);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_walk", {31'd0, bus.pred_taken}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
